rvee_axil_arb: RTL and testbench

RVEE_AXIL_ARB -- requirements
Module: rvee_axil_arb

---
 rtl/rvee_axil_pkg.sv | 26 ++
 rtl/rvee_axil_arb_if.sv | 51 +++++
 rtl/rvee_arb2.sv | 38 +++
 rtl/rvee_axil_arb.sv | 202 ++++++++++++++++++++
 tb/tb_rvee_axil_arb.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rvee_axil_pkg.sv
// ---------------------------------------------------------------------------
// rvee_axil_pkg
// Shared types and constants for the two-port AXI-lite arbiter.
//   state_t       : arbiter FSM states
//   RESP_OKAY/SLVERR : AXI response codes
//   owner_onehot  : converts the 1-bit owner index into a one-hot grant
// ---------------------------------------------------------------------------
package rvee_axil_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WADDR = 3'd3,
    WRESP = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Owner index 0 is s0 (fetch), 1 is s1 (mem).
  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rvee_axil_arb_if.sv
// ---------------------------------------------------------------------------
// rvee_axil_arb_if
// One AXI-lite link (aw, w, b, ar, r channels).
//   master modport : drives aw/w/ar payload + valids, bready, rready
//   slave modport  : drives awready, wready, arready, b and r payload + valids
// Parameters: AWIDTH (address width), DWIDTH (data width).
// ---------------------------------------------------------------------------
interface rvee_axil_arb_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              awvalid;
  logic              awready;
  logic [AWIDTH-1:0] awaddr;
  logic [2:0]        awprot;

  logic              wvalid;
  logic              wready;
  logic [DWIDTH-1:0] wdata;
  logic [DWIDTH/8-1:0] wstrb;

  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  logic              arvalid;
  logic              arready;
  logic [AWIDTH-1:0] araddr;
  logic [2:0]        arprot;

  logic              rvalid;
  logic              rready;
  logic [DWIDTH-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, awprot, input awready,
    output wvalid, wdata, wstrb, input wready,
    input  bvalid, bresp, output bready,
    output arvalid, araddr, arprot, input arready,
    input  rvalid, rdata, rresp, output rready
  );

  modport slave (
    input  awvalid, awaddr, awprot, output awready,
    input  wvalid, wdata, wstrb, output wready,
    output bvalid, bresp, input bready,
    input  arvalid, araddr, arprot, output arready,
    output rvalid, rdata, rresp, input rready
  );
endinterface

// File: rtl/rvee_arb2.sv
// ---------------------------------------------------------------------------
// rvee_arb2
// Two-requester tie-break, purely combinational.
//   req[1:0] : request per port (bit 0 = s0, bit 1 = s1)
//   last     : index of the port that owned the last completed transaction
//   gnt[1:0] : one-hot winner, 0 when nobody requests
// Macro RVEE_AXIL_ARB_RR_EN: defined -> round-robin on ties (the port that
// did not own the last transaction wins); undefined -> s1 always wins ties.
// ---------------------------------------------------------------------------
module rvee_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
`ifdef RVEE_AXIL_ARB_RR_EN
        gnt = last ? 2'b01 : 2'b10;
`else
        gnt = 2'b10;
`endif
      end
      default: gnt = 2'b00;
    endcase
  end

`ifndef RVEE_AXIL_ARB_RR_EN
  // Fixed priority has no use for the history input.
  logic unused_last;
  assign unused_last = last;
`endif

endmodule

// File: rtl/rvee_axil_arb.sv
// ---------------------------------------------------------------------------
// rvee_axil_arb
// Arbitrates two AXI-lite requesters (s0 = fetch, s1 = mem) onto one shared
// AXI-lite memory port, one transaction outstanding at a time.
//   aclk, aresetn : clock, asynchronous active-low reset
//   s0, s1        : target-side links (slave modport)
//   m             : shared memory link (master modport)
//   grant[1:0]    : one-hot current owner, 0 while idle
// Macro RVEE_AXIL_ARB_RR_EN: round-robin tie-break with a last-owner register
// (reset to s1). Undefined: fixed priority, s1 wins ties, no history kept.
// ---------------------------------------------------------------------------
module rvee_axil_arb
  import rvee_axil_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  rvee_axil_arb_if.slave    s0,
  rvee_axil_arb_if.slave    s1,
  rvee_axil_arb_if.master   m,
  output logic [1:0]        grant
);

  state_t state_reg, state_next;
  logic   owner_reg, owner_next;
  logic   aw_done_reg, aw_done_next;
  logic   w_done_reg, w_done_next;

  logic [1:0] req;
  logic [1:0] arb_gnt;
  logic       last_owner;
  logic       win_write;

  // Owner-selected request side signals.
  logic                sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
  logic [AWIDTH-1:0]   sel_awaddr, sel_araddr;
  logic [2:0]          sel_awprot, sel_arprot;
  logic [DWIDTH-1:0]   sel_wdata;
  logic [DWIDTH/8-1:0] sel_wstrb;

  logic aw_hs, w_hs, txn_done;

  assign req = {s1.awvalid | s1.arvalid, s0.awvalid | s0.arvalid};

  rvee_arb2 u_arb2 (
    .req  (req),
    .last (last_owner),
    .gnt  (arb_gnt)
  );

  // A port with both aw and ar pending is served write first.
  assign win_write = arb_gnt[1] ? s1.awvalid : (arb_gnt[0] & s0.awvalid);

`ifdef RVEE_AXIL_ARB_RR_EN
  logic last_reg;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      last_reg <= 1'b1;
    end else if (txn_done) begin
      last_reg <= owner_reg;
    end
  end

  assign last_owner = last_reg;
`else
  assign last_owner = 1'b1;
`endif

  assign sel_awvalid = owner_reg ? s1.awvalid : s0.awvalid;
  assign sel_awaddr  = owner_reg ? s1.awaddr  : s0.awaddr;
  assign sel_awprot  = owner_reg ? s1.awprot  : s0.awprot;
  assign sel_wvalid  = owner_reg ? s1.wvalid  : s0.wvalid;
  assign sel_wdata   = owner_reg ? s1.wdata   : s0.wdata;
  assign sel_wstrb   = owner_reg ? s1.wstrb   : s0.wstrb;
  assign sel_bready  = owner_reg ? s1.bready  : s0.bready;
  assign sel_arvalid = owner_reg ? s1.arvalid : s0.arvalid;
  assign sel_araddr  = owner_reg ? s1.araddr  : s0.araddr;
  assign sel_arprot  = owner_reg ? s1.arprot  : s0.arprot;
  assign sel_rready  = owner_reg ? s1.rready  : s0.rready;

  // Payloads pass straight through; only valid/ready are gated by state.
  assign m.awaddr = sel_awaddr;
  assign m.awprot = sel_awprot;
  assign m.wdata  = sel_wdata;
  assign m.wstrb  = sel_wstrb;
  assign m.araddr = sel_araddr;
  assign m.arprot = sel_arprot;

  assign s0.rdata = m.rdata;
  assign s0.rresp = m.rresp;
  assign s0.bresp = m.bresp;
  assign s1.rdata = m.rdata;
  assign s1.rresp = m.rresp;
  assign s1.bresp = m.bresp;

  // The aw and w channels complete independently; a done flag masks each
  // channel once its handshake has happened.
  assign aw_hs = (state_reg == WADDR) & sel_awvalid & ~aw_done_reg & m.awready;
  assign w_hs  = (state_reg == WADDR) & sel_wvalid  & ~w_done_reg  & m.wready;

  assign txn_done = ((state_reg == RDATA) & m.rvalid & sel_rready) |
                    ((state_reg == WRESP) & m.bvalid & sel_bready);

  assign grant = (state_reg == IDLE) ? 2'b00 : owner_onehot(owner_reg);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg   <= IDLE;
      owner_reg   <= 1'b0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;

    m.awvalid  = 1'b0;
    m.wvalid   = 1'b0;
    m.bready   = 1'b0;
    m.arvalid  = 1'b0;
    m.rready   = 1'b0;
    s0.awready = 1'b0;
    s0.wready  = 1'b0;
    s0.bvalid  = 1'b0;
    s0.arready = 1'b0;
    s0.rvalid  = 1'b0;
    s1.awready = 1'b0;
    s1.wready  = 1'b0;
    s1.bvalid  = 1'b0;
    s1.arready = 1'b0;
    s1.rvalid  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (|req) begin
          owner_next = arb_gnt[1];
          state_next = win_write ? WADDR : RADDR;
        end
      end

      RADDR: begin
        m.arvalid  = sel_arvalid;
        s0.arready = ~owner_reg & m.arready;
        s1.arready =  owner_reg & m.arready;
        if (sel_arvalid && m.arready) begin
          state_next = RDATA;
        end
      end

      RDATA: begin
        m.rready  = sel_rready;
        s0.rvalid = ~owner_reg & m.rvalid;
        s1.rvalid =  owner_reg & m.rvalid;
        if (txn_done) begin
          state_next = IDLE;
        end
      end

      WADDR: begin
        m.awvalid  = sel_awvalid & ~aw_done_reg;
        m.wvalid   = sel_wvalid & ~w_done_reg;
        s0.awready = ~owner_reg & ~aw_done_reg & m.awready;
        s1.awready =  owner_reg & ~aw_done_reg & m.awready;
        s0.wready  = ~owner_reg & ~w_done_reg & m.wready;
        s1.wready  =  owner_reg & ~w_done_reg & m.wready;
        aw_done_next = aw_done_reg | aw_hs;
        w_done_next  = w_done_reg | w_hs;
        if ((aw_done_reg | aw_hs) && (w_done_reg | w_hs)) begin
          state_next = WRESP;
        end
      end

      WRESP: begin
        m.bready  = sel_bready;
        s0.bvalid = ~owner_reg & m.bvalid;
        s1.bvalid =  owner_reg & m.bvalid;
        if (txn_done) begin
          state_next   = IDLE;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rvee_axil_arb.sv
// ---------------------------------------------------------------------------
// tb_rvee_axil_arb
// Directed bench: two requesters driven from tasks, a behavioural memory
// slave on the shared port, hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_rvee_axil_arb;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [1:0] grant;
  int cyc = 0;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  rvee_axil_arb_if #(.AWIDTH(32), .DWIDTH(32)) s0_if ();
  rvee_axil_arb_if #(.AWIDTH(32), .DWIDTH(32)) s1_if ();
  rvee_axil_arb_if #(.AWIDTH(32), .DWIDTH(32)) m_if ();

  rvee_axil_arb #(.AWIDTH(32), .DWIDTH(32)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s0      (s0_if),
    .s1      (s1_if),
    .m       (m_if),
    .grant   (grant)
  );

  // Requester-side drive, index 0 = s0, 1 = s1.
  logic        awvalid_d [2];
  logic [31:0] awaddr_d  [2];
  logic [2:0]  awprot_d  [2];
  logic        wvalid_d  [2];
  logic [31:0] wdata_d   [2];
  logic [3:0]  wstrb_d   [2];
  logic        bready_d  [2];
  logic        arvalid_d [2];
  logic [31:0] araddr_d  [2];
  logic [2:0]  arprot_d  [2];
  logic        rready_d  [2];

  logic        awready_o [2];
  logic        wready_o  [2];
  logic        bvalid_o  [2];
  logic [1:0]  bresp_o   [2];
  logic        arready_o [2];
  logic        rvalid_o  [2];
  logic [31:0] rdata_o   [2];
  logic [1:0]  rresp_o   [2];

  assign s0_if.awvalid = awvalid_d[0];  assign s1_if.awvalid = awvalid_d[1];
  assign s0_if.awaddr  = awaddr_d[0];   assign s1_if.awaddr  = awaddr_d[1];
  assign s0_if.awprot  = awprot_d[0];   assign s1_if.awprot  = awprot_d[1];
  assign s0_if.wvalid  = wvalid_d[0];   assign s1_if.wvalid  = wvalid_d[1];
  assign s0_if.wdata   = wdata_d[0];    assign s1_if.wdata   = wdata_d[1];
  assign s0_if.wstrb   = wstrb_d[0];    assign s1_if.wstrb   = wstrb_d[1];
  assign s0_if.bready  = bready_d[0];   assign s1_if.bready  = bready_d[1];
  assign s0_if.arvalid = arvalid_d[0];  assign s1_if.arvalid = arvalid_d[1];
  assign s0_if.araddr  = araddr_d[0];   assign s1_if.araddr  = araddr_d[1];
  assign s0_if.arprot  = arprot_d[0];   assign s1_if.arprot  = arprot_d[1];
  assign s0_if.rready  = rready_d[0];   assign s1_if.rready  = rready_d[1];

  assign awready_o[0] = s0_if.awready;  assign awready_o[1] = s1_if.awready;
  assign wready_o[0]  = s0_if.wready;   assign wready_o[1]  = s1_if.wready;
  assign bvalid_o[0]  = s0_if.bvalid;   assign bvalid_o[1]  = s1_if.bvalid;
  assign bresp_o[0]   = s0_if.bresp;    assign bresp_o[1]   = s1_if.bresp;
  assign arready_o[0] = s0_if.arready;  assign arready_o[1] = s1_if.arready;
  assign rvalid_o[0]  = s0_if.rvalid;   assign rvalid_o[1]  = s1_if.rvalid;
  assign rdata_o[0]   = s0_if.rdata;    assign rdata_o[1]   = s1_if.rdata;
  assign rresp_o[0]   = s0_if.rresp;    assign rresp_o[1]   = s1_if.rresp;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory slave model ----------------
  logic [31:0] rdata_val = 32'h0;
  logic [1:0]  bresp_val = 2'b00;
  int          w_delay   = 0;
  bit          r_stall   = 0;

  bit rvalid_s, bvalid_s, aw_seen, w_seen;
  int wcnt;
  bit ar_hs, r_hs, aw_hs, w_hs, b_hs, arv_prev;
  int m_ar_cnt = 0, m_aw_cnt = 0, m_w_cnt = 0, m_b_cnt = 0;
  int ar_rise_cyc = 0, b_hs_cyc = 0;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb;
  logic [2:0]  cap_awprot, cap_arprot;
  int s_b_cnt [2] = '{0, 0};
  int s_r_cnt [2] = '{0, 0};
  int viol = 0;

  initial begin
    m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.arready = 1'b0;
    m_if.bvalid = 1'b0; m_if.bresp = 2'b00;
    m_if.rvalid = 1'b0; m_if.rdata = 32'h0; m_if.rresp = 2'b00;
  end

  always begin
    @(negedge aclk);
    if (!aresetn) begin
      rvalid_s = 0; bvalid_s = 0; aw_seen = 0; w_seen = 0; wcnt = 0;
      ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
    end else begin
      if (r_hs) rvalid_s = 0;
      if (ar_hs && !r_stall) rvalid_s = 1;
      if (b_hs) begin bvalid_s = 0; aw_seen = 0; w_seen = 0; wcnt = 0; end
      if (aw_hs) aw_seen = 1;
      if (w_hs) w_seen = 1;
      if (aw_seen && !w_seen) wcnt++;
      if (aw_seen && w_seen && !bvalid_s) bvalid_s = 1;
    end
    m_if.arready = aresetn;
    m_if.awready = aresetn;
    m_if.wready  = aresetn && (w_delay == 0 || (aw_seen && wcnt > w_delay));
    m_if.rvalid  = rvalid_s;
    m_if.rdata   = rdata_val;
    m_if.rresp   = 2'b00;
    m_if.bvalid  = bvalid_s;
    m_if.bresp   = bresp_val;
    #1;
    // Values now stable until the next rising edge, where they take effect.
    ar_hs = m_if.arvalid && m_if.arready;
    r_hs  = m_if.rvalid && m_if.rready;
    aw_hs = m_if.awvalid && m_if.awready;
    w_hs  = m_if.wvalid && m_if.wready;
    b_hs  = m_if.bvalid && m_if.bready;
    if (m_if.arvalid && !arv_prev) ar_rise_cyc = cyc;
    arv_prev = m_if.arvalid;
    if (ar_hs) begin m_ar_cnt++; cap_araddr = m_if.araddr; cap_arprot = m_if.arprot; end
    if (aw_hs) begin m_aw_cnt++; cap_awaddr = m_if.awaddr; cap_awprot = m_if.awprot; end
    if (w_hs)  begin m_w_cnt++; cap_wdata = m_if.wdata; cap_wstrb = m_if.wstrb; end
    if (b_hs)  begin m_b_cnt++; b_hs_cyc = cyc; end
    for (int p = 0; p < 2; p++) begin
      if (bvalid_o[p] && bready_d[p]) s_b_cnt[p]++;
      if (rvalid_o[p] && rready_d[p]) s_r_cnt[p]++;
    end
    // Only the granted port may see any valid or ready.
    if (grant != 2'b01 && (s0_if.arready || s0_if.rvalid || s0_if.awready ||
                           s0_if.wready || s0_if.bvalid)) viol++;
    if (grant != 2'b10 && (s1_if.arready || s1_if.rvalid || s1_if.awready ||
                           s1_if.wready || s1_if.bvalid)) viol++;
  end

  // ---------------- requester tasks ----------------
  int req_cyc [2];
  int order_q [$];

  task automatic rd(input int p, input logic [31:0] addr,
                    output logic [31:0] data, output logic [1:0] resp);
    bit ok;
    data = 32'h0;
    resp = 2'b11;
    @(negedge aclk);
    arvalid_d[p] = 1'b1; araddr_d[p] = addr; rready_d[p] = 1'b1;
    req_cyc[p] = cyc;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      #2;
      if (arready_o[p]) begin ok = 1; break; end
      @(negedge aclk);
    end
    check($sformatf("rd%0d_ar_hs", p), 64'(ok), 64'd1);
    @(negedge aclk);
    arvalid_d[p] = 1'b0;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      #2;
      if (rvalid_o[p]) begin ok = 1; data = rdata_o[p]; resp = rresp_o[p]; break; end
      @(negedge aclk);
    end
    check($sformatf("rd%0d_r_hs", p), 64'(ok), 64'd1);
    @(negedge aclk);
    rready_d[p] = 1'b0;
    order_q.push_back(p);
    $display("read  s%0d addr=%h data=%h resp=%0d", p, addr, data, resp);
  endtask

  task automatic wr(input int p, input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, output logic [1:0] resp);
    bit aw_ok, w_ok, b_ok;
    resp = 2'b11;
    @(negedge aclk);
    awvalid_d[p] = 1'b1; awaddr_d[p] = addr;
    wvalid_d[p] = 1'b1; wdata_d[p] = data; wstrb_d[p] = strb; bready_d[p] = 1'b1;
    aw_ok = 0; w_ok = 0;
    for (int n = 0; n < 100 && !(aw_ok && w_ok); n++) begin
      #2;
      if (awvalid_d[p] && awready_o[p]) aw_ok = 1;
      if (wvalid_d[p] && wready_o[p]) w_ok = 1;
      @(negedge aclk);
      if (aw_ok) awvalid_d[p] = 1'b0;
      if (w_ok) wvalid_d[p] = 1'b0;
    end
    check($sformatf("wr%0d_aw_hs", p), 64'(aw_ok), 64'd1);
    check($sformatf("wr%0d_w_hs", p), 64'(w_ok), 64'd1);
    b_ok = 0;
    for (int n = 0; n < 100; n++) begin
      #2;
      if (bvalid_o[p]) begin b_ok = 1; resp = bresp_o[p]; break; end
      @(negedge aclk);
    end
    check($sformatf("wr%0d_b_hs", p), 64'(b_ok), 64'd1);
    @(negedge aclk);
    bready_d[p] = 1'b0;
    $display("write s%0d addr=%h data=%h strb=%h resp=%0d", p, addr, data, strb, resp);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  logic [31:0] d0, d1;
  logic [1:0]  r0, r1, wresp;
  int ar0, aw0, w0, b0, sr0;
  int first_exp;
  bit ok;

  initial begin
    for (int p = 0; p < 2; p++) begin
      awvalid_d[p] = 0; awaddr_d[p] = 0; awprot_d[p] = 0;
      wvalid_d[p] = 0; wdata_d[p] = 0; wstrb_d[p] = 0; bready_d[p] = 0;
      arvalid_d[p] = 0; araddr_d[p] = 0; arprot_d[p] = 0; rready_d[p] = 0;
    end

    // Reset state
    #12;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_m_arvalid", 64'(m_if.arvalid), 64'd0);
    check("rst_m_awvalid", 64'(m_if.awvalid), 64'd0);
    check("rst_m_wvalid", 64'(m_if.wvalid), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    // Single read from s0, zero-wait slave
    rdata_val = 32'hDEADBEEF;
    arprot_d[0] = 3'b100;
    rd(0, 32'h100, d0, r0);
    check("r028_latency", 64'(ar_rise_cyc - req_cyc[0]), 64'd1);
    check("r028_araddr", 64'(cap_araddr), 64'h100);
    check("r028_arprot", 64'(cap_arprot), 64'd4);
    check("r028_rdata", 64'(d0), 64'hDEADBEEF);
    check("r028_rresp", 64'(r0), 64'd0);
    #2;
    check("r028_grant_idle", 64'(grant), 64'd0);

    // Write from s1, wready lagging awready
    w_delay = 3;
    awprot_d[1] = 3'b010;
    aw0 = m_aw_cnt; w0 = m_w_cnt; b0 = s_b_cnt[1];
    wr(1, 32'h2000, 32'h12345678, 4'hF, wresp);
    w_delay = 0;
    repeat (2) @(negedge aclk);
    check("w029_aw_count", 64'(m_aw_cnt - aw0), 64'd1);
    check("w029_w_count", 64'(m_w_cnt - w0), 64'd1);
    check("w029_s1_bvalid_count", 64'(s_b_cnt[1] - b0), 64'd1);
    check("w029_awaddr", 64'(cap_awaddr), 64'h2000);
    check("w029_awprot", 64'(cap_awprot), 64'd2);
    check("w029_wdata", 64'(cap_wdata), 64'h12345678);
    check("w029_wstrb", 64'(cap_wstrb), 64'hF);
    check("w029_bresp", 64'(wresp), 64'd0);

    // Tie between s0 and s1 reads; last owner is s1 after the write
    rdata_val = 32'hA5A5_0001;
    order_q.delete();
    fork
      rd(0, 32'h10, d0, r0);
      rd(1, 32'h20, d1, r1);
    join
`ifdef RVEE_AXIL_ARB_RR_EN
    first_exp = 0;
`else
    first_exp = 1;
`endif
    check("t030a_first", 64'(order_q[0]), 64'(first_exp));
    check("t030a_second", 64'(order_q[1]), 64'(1 - first_exp));
    check("t030a_d0", 64'(d0), 64'hA5A5_0001);
    check("t030a_d1", 64'(d1), 64'hA5A5_0001);

    // s0 owns the last transaction, then tie again: RR picks s1 this time
    rd(0, 32'h30, d0, r0);
    order_q.delete();
    fork
      rd(0, 32'h40, d0, r0);
      rd(1, 32'h50, d1, r1);
    join
    check("t030b_first", 64'(order_q[0]), 64'd1);
    check("t030b_second", 64'(order_q[1]), 64'd0);

    // s1 raises awvalid and arvalid together; write goes first, SLVERR back
    bresp_val = 2'b10;
    rdata_val = 32'h0BAD_F00D;
    fork
      wr(1, 32'h3000, 32'h55AA55AA, 4'h3, wresp);
      rd(1, 32'h3004, d1, r1);
    join
    bresp_val = 2'b00;
    check("w031_bresp", 64'(wresp), 64'd2);
    check("w031_write_first", 64'(b_hs_cyc < ar_rise_cyc), 64'd1);
    check("w031_rdata", 64'(d1), 64'h0BAD_F00D);
    check("w031_wstrb", 64'(cap_wstrb), 64'h3);

    // Reset while the read sits in RDATA
    r_stall = 1;
    ar0 = m_ar_cnt; sr0 = s_r_cnt[0];
    @(negedge aclk);
    arvalid_d[0] = 1'b1; araddr_d[0] = 32'h300; rready_d[0] = 1'b1;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      #2;
      if (arready_o[0]) begin ok = 1; break; end
      @(negedge aclk);
    end
    check("r032_ar_hs", 64'(ok), 64'd1);
    @(negedge aclk);
    arvalid_d[0] = 1'b0;
    #2;
    check("r032_grant_rdata", 64'(grant), 64'd1);
    check("r032_m_rready_rdata", 64'(m_if.rready), 64'd1);
    #1;
    aresetn = 1'b0;
    #1;
    check("r032_grant_rst", 64'(grant), 64'd0);
    check("r032_m_rready_rst", 64'(m_if.rready), 64'd0);
    check("r032_m_arvalid_rst", 64'(m_if.arvalid), 64'd0);
    check("r032_s0_arready_rst", 64'(s0_if.arready), 64'd0);
    $display("reset asserted during RDATA at cycle %0d", cyc);
    @(negedge aclk);
    rready_d[0] = 1'b0;
    r_stall = 0;
    @(negedge aclk);
    aresetn = 1'b1;
    check("r032_no_completion", 64'(s_r_cnt[0] - sr0), 64'd0);
    check("r032_ar_count", 64'(m_ar_cnt - ar0), 64'd1);
    rdata_val = 32'hCAFE_F00D;
    rd(0, 32'h400, d0, r0);
    check("r032_after_rdata", 64'(d0), 64'hCAFE_F00D);
    check("r032_after_araddr", 64'(cap_araddr), 64'h400);

    check("nonowner_quiet", 64'(viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
